// File: rtl/calc_op_sequencer_if.sv
// Command/result handshake bundle between operand entry, the op sequencer and the result logic.
// The entry/display side uses the master modport; the sequencer uses the slave modport.
interface calc_op_sequencer_if;
    logic       start_valid;
    logic       start_ready;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result;
    logic       err;
    logic       neg;
    logic       busy;

    modport master (
        output start_valid, op, a, b, result_ready,
        input  start_ready, result_valid, result, err, neg, busy
    );

    modport slave (
        input  start_valid, op, a, b, result_ready,
        output start_ready, result_valid, result, err, neg, busy
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator op sequencer: steps one shared 8-bit add/sub unit through add, sub,
// 4-step shift-add multiply and 4-step restoring divide, with valid/ready on both sides.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   st_idle | waiting for a command, start_ready high
//   st_exec | one add/sub step per cycle, down-counter tracks steps left
//   st_done | result/err/neg held, result_valid high until result_ready
module calc_op_sequencer (
    input  logic               clk,
    input  logic               rst,
    calc_op_sequencer_if.slave bus
);

    localparam logic [1:0] op_add = 2'b00;
    localparam logic [1:0] op_sub = 2'b01;
    localparam logic [1:0] op_mul = 2'b10;
    localparam logic [1:0] op_div = 2'b11;

    typedef enum logic [1:0] {
        st_idle = 2'b00,
        st_exec = 2'b01,
        st_done = 2'b10
    } state_t;

    state_t     state;
    state_t     state_d;

    logic [1:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] cnt;
    logic [7:0] acc;
    logic [7:0] mcand;
    logic [3:0] mplr;
    logic [3:0] rem_q;
    logic [3:0] dq;
    logic [7:0] result_q;
    logic       err_q;
    logic       neg_q;

    logic       accept;
    logic       div_zero_in;
    logic       last_step;

    logic [7:0] add_x;
    logic [7:0] add_y;
    logic       add_sub;
    logic [7:0] add_sum;

    logic [7:0] acc_step;
    logic       trial_ok;
    logic [3:0] rem_step;
    logic [3:0] dq_step;
    logic [7:0] final_result;
    logic       final_err;
    logic       final_neg;

    assign accept      = (state == st_idle) && bus.start_valid;
    assign div_zero_in = (bus.op == op_div) && (bus.b == 4'd0);
    assign last_step   = (cnt == 2'd0);

    // Operand steering for the single shared add/sub unit.
    always_comb begin
        add_x   = 8'h00;
        add_y   = 8'h00;
        add_sub = 1'b0;
        unique case (op_q)
            op_add: begin
                add_x = {4'b0, a_q};
                add_y = {4'b0, b_q};
            end
            op_sub: begin
                add_x   = {4'b0, a_q};
                add_y   = {4'b0, b_q};
                add_sub = 1'b1;
            end
            op_mul: begin
                add_x = acc;
                add_y = mcand;
            end
            op_div: begin
                add_x   = {3'b0, rem_q, dq[3]};
                add_y   = {4'b0, b_q};
                add_sub = 1'b1;
            end
        endcase
    end

    assign add_sum = add_x + (add_sub ? ~add_y : add_y) + {7'b0, add_sub};

    // Partial remainder never exceeds 5 bits, so bit 7 of the trial difference is its sign.
    assign acc_step = mplr[0] ? add_sum : acc;
    assign trial_ok = ~add_sum[7];
    assign rem_step = trial_ok ? add_sum[3:0] : {rem_q[2:0], dq[3]};
    assign dq_step  = {dq[2:0], trial_ok};

    always_comb begin
        final_result = add_sum;
        final_err    = 1'b0;
        final_neg    = 1'b0;
        unique case (op_q)
            op_add: final_result = add_sum;
            op_sub: begin
                final_result = add_sum;
                final_neg    = add_sum[7];
            end
            op_mul: final_result = acc_step;
            op_div: begin
                if (b_q == 4'd0) begin
                    final_result = 8'h00;
                    final_err    = 1'b1;
                end else begin
                    final_result = {rem_step, dq_step};
                end
            end
        endcase
    end

    always_comb begin
        state_d = state;
        unique case (state)
            st_idle: if (bus.start_valid) state_d = st_exec;
            st_exec: if (last_step)       state_d = st_done;
            st_done: if (bus.result_ready) state_d = st_idle;
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            op_q     <= op_add;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            cnt      <= 2'd0;
            acc      <= 8'h00;
            mcand    <= 8'h00;
            mplr     <= 4'd0;
            rem_q    <= 4'd0;
            dq       <= 4'd0;
            result_q <= 8'h00;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q  <= bus.op;
                a_q   <= bus.a;
                b_q   <= bus.b;
                // Divide by zero skips the iterations and resolves after a single step.
                cnt   <= (bus.op[1] && !div_zero_in) ? 2'd3 : 2'd0;
                acc   <= 8'h00;
                mcand <= {4'b0, bus.a};
                mplr  <= bus.b;
                rem_q <= 4'd0;
                dq    <= bus.a;
            end else if (state == st_exec) begin
                cnt   <= cnt - 2'd1;
                acc   <= acc_step;
                mcand <= {mcand[6:0], 1'b0};
                mplr  <= {1'b0, mplr[3:1]};
                rem_q <= rem_step;
                dq    <= dq_step;
                if (last_step) begin
                    result_q <= final_result;
                    err_q    <= final_err;
                    neg_q    <= final_neg;
                end
            end
        end
    end

    assign bus.start_ready  = (state == st_idle);
    assign bus.result_valid = (state == st_done);
    assign bus.busy         = (state != st_idle);
    assign bus.result       = result_q;
    assign bus.err          = err_q;
    assign bus.neg          = neg_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed cases plus random commands checked against
// an arithmetic reference model, including backpressure and mid-operation reset.
module tb_calc_op_sequencer;
    logic clk = 1'b0;
    logic rst;

    calc_op_sequencer_if bus();

    calc_op_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] op, input int a, input int b,
                                      output logic [7:0] res, output logic err,
                                      output logic neg, output int lat);
        err = 1'b0;
        neg = 1'b0;
        lat = 1;
        res = 8'h00;
        case (op)
            2'b00: res = 8'(a + b);
            2'b01: begin
                res = 8'(a - b);
                neg = (a < b);
            end
            2'b10: begin
                res = 8'(a * b);
                lat = 4;
            end
            default: begin
                if (b == 0) begin
                    err = 1'b1;
                end else begin
                    res = 8'((a % b) * 16 + (a / b));
                    lat = 4;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, hold off result_ready for 'hold' cycles in DONE, then complete the handshake.
    task automatic run_cmd(input logic [1:0] op, input int a, input int b, input int hold, input string tag);
        logic [7:0] er;
        logic       ee;
        logic       en;
        int         el;
        int         lat;
        ref_model(op, a, b, er, ee, en, el);
        check({tag, ":idle_ready"}, 32'(bus.start_ready), 32'd1);
        bus.start_valid  = 1'b1;
        bus.op           = op;
        bus.a            = 4'(a);
        bus.b            = 4'(b);
        bus.result_ready = (hold == 0);
        tick();
        bus.start_valid = 1'b0;
        bus.op          = 2'($urandom);
        bus.a           = 4'($urandom);
        bus.b           = 4'($urandom);
        lat = 0;
        while (!bus.result_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(el));
        check({tag, ":result"}, 32'(bus.result), 32'(er));
        check({tag, ":err"}, 32'(bus.err), 32'(ee));
        check({tag, ":neg"}, 32'(bus.neg), 32'(en));
        check({tag, ":busy_done"}, 32'({bus.busy, bus.start_ready}), 32'b10);
        for (int i = 0; i < hold; i++) begin
            bus.start_valid = (i == 1);
            tick();
            bus.start_valid = 1'b0;
            check({tag, ":hold_valid"}, 32'({bus.result_valid, bus.start_ready}), 32'b10);
            check({tag, ":hold_result"}, 32'({bus.result, bus.err, bus.neg}), 32'({er, ee, en}));
        end
        bus.result_ready = 1'b1;
        tick();
        check({tag, ":back_idle"}, 32'({bus.result_valid, bus.start_ready, bus.busy}), 32'b010);
        bus.result_ready = 1'b0;
    endtask

    initial begin
        logic seen_rv;
        rst              = 1'b1;
        bus.start_valid  = 1'b0;
        bus.op           = 2'b00;
        bus.a            = 4'd0;
        bus.b            = 4'd0;
        bus.result_ready = 1'b0;
        tick();
        tick();
        check("reset_state", 32'({bus.start_ready, bus.result_valid, bus.result, bus.err, bus.neg, bus.busy}),
              32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        tick();

        run_cmd(2'b00, 6, 3, 0, "add_6_3");
        run_cmd(2'b01, 1, 3, 0, "sub_1_3");
        run_cmd(2'b01, 8, 2, 0, "sub_8_2");
        run_cmd(2'b10, 15, 15, 0, "mul_15_15");
        run_cmd(2'b10, 0, 9, 0, "mul_0_9");
        run_cmd(2'b11, 13, 4, 0, "div_13_4");
        run_cmd(2'b11, 13, 0, 0, "div_by_0");
        run_cmd(2'b10, 7, 3, 5, "mul_backpressure");
        run_cmd(2'b01, 0, 15, 0, "sub_0_15");
        run_cmd(2'b11, 15, 1, 0, "div_15_1");

        // Reset in the middle of a multiply.
        bus.start_valid = 1'b1;
        bus.op          = 2'b10;
        bus.a           = 4'd7;
        bus.b           = 4'd5;
        tick();
        bus.start_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("midop_reset", 32'({bus.start_ready, bus.result_valid, bus.result, bus.err, bus.neg, bus.busy}),
              32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        seen_rv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.result_valid) seen_rv = 1'b1;
        end
        check("midop_no_result", 32'(seen_rv), 32'd0);
        run_cmd(2'b00, 9, 9, 0, "add_after_reset");

        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
